// File: rtl/ser_pkg.sv
// Shared state encoding and default idle level for bit_serializer.
// The PARITY state is only reachable when SER_PARITY_EN is defined.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_t;

    localparam logic SER_IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clk out.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = SER_IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_bit;
`endif

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
    assign accept   = din_valid && din_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        din_ready  = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) next_state = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef SER_PARITY_EN
                    next_state = PARITY;
`else
                    din_ready  = 1'b1;
                    word_done  = 1'b1;
                    next_state = din_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                din_ready  = 1'b1;
                word_done  = 1'b1;
                next_state = din_valid ? SHIFT : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // ser_out always shows the bit indexed by bit_cnt; shreg holds the bits still to come.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
`ifdef SER_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else if (accept) begin
            shreg     <= MSB_FIRST ? (din << 1) : (din >> 1);
            ser_out   <= MSB_FIRST ? din[WIDTH-1] : din[0];
            bit_cnt   <= '0;
            ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
            par_bit   <= ^din;
`endif
        end else if (state == SHIFT) begin
            if (!last_bit) begin
                shreg     <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                ser_out   <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                bit_cnt   <= bit_cnt + CNT_W'(1);
                ser_valid <= 1'b1;
            end else begin
`ifdef SER_PARITY_EN
                ser_out   <= par_bit;
                ser_valid <= 1'b1;
`else
                ser_out   <= IDLE_LEVEL;
                ser_valid <= 1'b0;
`endif
            end
        end else if (state == PARITY) begin
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first and LSB-first instances against a bit-queue model.
// Honours SER_PARITY_EN when the build defines it.
module tb_bit_serializer;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             din_valid;
    logic [WIDTH-1:0] din;

    logic ready_m, sout_m, sval_m, done_m, busy_m;
    logic ready_l, sout_l, sval_l, done_l, busy_l;

    int vectors     = 0;
    int miscompares = 0;

    // Model: bits still to appear on ser_out, head = bit currently shown.
    bit   qm[$];
    bit   ql[$];
    logic [4:0] exp_m, exp_l;
    bit   last_accept;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready_m),
        .ser_out(sout_m), .ser_valid(sval_m), .word_done(done_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready_l),
        .ser_out(sout_l), .ser_valid(sval_l), .word_done(done_l), .busy(busy_l)
    );

    // Expected {ser_valid, ser_out, word_done, busy, din_ready} from the number of pending bits.
    function automatic logic [4:0] pack_exp(input int sz, input bit head);
        return {sz > 0, (sz > 0) ? head : 1'b0, sz == 1, sz > 0, sz <= 1};
    endfunction

    function automatic logic [4:0] obs_m();
        return {sval_m, sout_m, done_m, busy_m, ready_m};
    endfunction

    function automatic logic [4:0] obs_l();
        return {sval_l, sout_l, done_l, busy_l, ready_l};
    endfunction

    task automatic load_word(input logic [WIDTH-1:0] w);
        qm.delete();
        ql.delete();
        for (int i = WIDTH - 1; i >= 0; i--) qm.push_back(w[i]);
        for (int i = 0; i < WIDTH; i++) ql.push_back(w[i]);
`ifdef SER_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
    endtask

    task automatic update_exp();
        exp_m = pack_exp(qm.size(), (qm.size() > 0) ? qm[0] : 1'b0);
        exp_l = pack_exp(ql.size(), (ql.size() > 0) ? ql[0] : 1'b0);
    endtask

    // One rising edge; inputs are sampled by the model exactly as the spec's accept rule says.
    task automatic step();
        bit acc;
        acc = din_valid && !reset && (qm.size() <= 1);
        @(posedge clk);
        if (reset) begin
            qm.delete();
            ql.delete();
        end else if (acc) begin
            load_word(din);
        end else if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        last_accept = acc;
        #1;
        update_exp();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        din_valid = 1'b1;
        din       = 8'hD0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs_m() !== exp_m) begin
                miscompares++;
                $display("FAIL reset_hold_msb cycle %0d: got %b want %b", i, obs_m(), exp_m);
            end
            vectors++;
            if (obs_l() !== exp_l) begin
                miscompares++;
                $display("FAIL reset_hold_lsb cycle %0d: got %b want %b", i, obs_l(), exp_l);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({sval_m, sout_m, busy_m, ready_m} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_release: got {valid,out,busy,ready}=%b want 0001",
                     {sval_m, sout_m, busy_m, ready_m});
        end
        din_valid = 1'b0;
    endtask

    // Sends one word, runs until idle, and checks every cycle plus the collected stream.
    task automatic run_single(input string name, input logic [WIDTH-1:0] w, input bit use_lsb,
                              input logic [15:0] want_stream);
        logic [15:0] stream = '0;
        int          nbits  = 0;
        int          ndone  = 0;
        din       = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din       = $urandom;
        for (int i = 0; i < WIDTH + 3; i++) begin
            vectors++;
            if (obs_m() !== exp_m) begin
                miscompares++;
                $display("FAIL %s_msb cycle %0d: got %b want %b", name, i, obs_m(), exp_m);
            end
            vectors++;
            if (obs_l() !== exp_l) begin
                miscompares++;
                $display("FAIL %s_lsb cycle %0d: got %b want %b", name, i, obs_l(), exp_l);
            end
            if (use_lsb ? sval_l : sval_m) begin
                stream = {stream[14:0], use_lsb ? sout_l : sout_m};
                nbits++;
            end
            if (use_lsb ? done_l : done_m) ndone++;
            step();
        end
        vectors++;
`ifdef SER_PARITY_EN
        if (nbits != WIDTH + 1 || stream !== want_stream || ndone != 1) begin
`else
        if (nbits != WIDTH || stream !== want_stream || ndone != 1) begin
`endif
            miscompares++;
            $display("FAIL %s_stream: got %0d bits %h done=%0d want %h done=1",
                     name, nbits, stream, ndone, want_stream);
        end
    endtask

    task automatic test_single_word();
`ifdef SER_PARITY_EN
        run_single("single_d0", 8'hD0, 1'b0, 16'h01A1);
        run_single("single_c0", 8'hC0, 1'b0, 16'h0180);
`else
        run_single("single_d0", 8'hD0, 1'b0, 16'h00D0);
`endif
    endtask

    task automatic test_lsb_first();
`ifdef SER_PARITY_EN
        run_single("lsb_0b", 8'h0B, 1'b1, 16'h01A1);
`else
        run_single("lsb_0b", 8'h0B, 1'b1, 16'h00D0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream = '0;
        int          nvalid = 0;
        int          runs   = 0;
        bit          prev   = 1'b0;
        din       = 8'hA5;
        din_valid = 1'b1;
        for (int i = 0; i < 3 * WIDTH + 4; i++) begin
            step();
            if (last_accept && din == 8'hA5) din = 8'h3C;
            else if (last_accept) din_valid = 1'b0;
            vectors++;
            if (obs_m() !== exp_m) begin
                miscompares++;
                $display("FAIL b2b_msb cycle %0d: got %b want %b", i, obs_m(), exp_m);
            end
            if (sval_m) begin
                stream = {stream[30:0], sout_m};
                nvalid++;
                if (!prev) runs++;
            end
            prev = sval_m;
        end
        vectors++;
`ifdef SER_PARITY_EN
        if (nvalid != 18 || runs != 1 || stream[17:0] !== {8'hA5, 1'b0, 8'h3C, 1'b0}) begin
`else
        if (nvalid != 16 || runs != 1 || stream[15:0] !== 16'hA53C) begin
`endif
            miscompares++;
            $display("FAIL b2b_stream: got %0d bits in %0d runs, bits %h", nvalid, runs, stream);
        end
    endtask

    task automatic test_abort();
        din       = 8'hFF;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (obs_m() !== exp_m) begin
            miscompares++;
            $display("FAIL abort_pre: got %b want %b", obs_m(), exp_m);
        end
        #2;
        reset     = 1'b1;
        din_valid = 1'b1;
        qm.delete();
        ql.delete();
        #1;
        update_exp();
        vectors++;
        if (obs_m() !== exp_m || done_m !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_async: got %b want %b", obs_m(), exp_m);
        end
        step();
        step();
        reset     = 1'b0;
        din_valid = 1'b0;
        #1;
        vectors++;
        if (busy_m !== 1'b0 || sval_m !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_release: got busy=%b valid=%b want 0 0", busy_m, sval_m);
        end
        test_single_word();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            din       = $urandom;
            din_valid = ($urandom_range(0, 3) != 0);
            step();
            vectors++;
            if (obs_m() !== exp_m) begin
                miscompares++;
                $display("FAIL random_msb cycle %0d: got %b want %b", i, obs_m(), exp_m);
            end
            vectors++;
            if (obs_l() !== exp_l) begin
                miscompares++;
                $display("FAIL random_lsb cycle %0d: got %b want %b", i, obs_l(), exp_l);
            end
            if ($urandom_range(0, 59) == 0) begin
                #2;
                reset = 1'b1;
                qm.delete();
                ql.delete();
                #1;
                update_exp();
                vectors++;
                if (obs_m() !== exp_m || obs_l() !== exp_l) begin
                    miscompares++;
                    $display("FAIL random_reset cycle %0d: got %b/%b want %b/%b",
                             i, obs_m(), obs_l(), exp_m, exp_l);
                end
                #1;
                reset = 1'b0;
            end
        end
        din_valid = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) step();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_lsb_first();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
